// File: rtl/io_ctrl.sv
// ---------------------------------------------------------------------------
// io_ctrl -- memory-mapped I/O controller between the CPU data bus and the
// data memory. Decodes a five-word register bank at 0x800..0x810, steers
// read data between that bank and data memory, and suppresses data-memory
// writes that hit the bank.
//
// Register map (unused bits read 0):
//   0x800 OUT    R/W   [7:0] drive out_pins
//   0x804 IN     RO    [7:0] synchronized + debounced in_pins
//   0x808 EDGE   R/W1C [7:0] sticky rising-edge capture of IN
//   0x80C TIMER  W: reload and count <= wdata; R: current count
//   0x810 STATUS R/W1C [0] sticky timer expiry
//
// Ports:
//   clk, reset       clock (rising edge), asynchronous active-high reset
//   addr, wdata, we  CPU data address, write data, write strobe
//   re               CPU read strobe (reads have no side effects)
//   mem_rdata        data-memory read data
//   mem_we           data-memory write enable (we gated off on I/O hits)
//   rdata            read data returned to the CPU
//   sel              I/O register hit
//   in_pins          raw asynchronous inputs
//   out_pins         OUT register
//   timer_irq        STATUS.expired
// ---------------------------------------------------------------------------
module io_ctrl #(
    parameter int DB_CYCLES = 4,
    parameter int TMR_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic [31:0] rdata,
    output logic        sel,
    input  logic [7:0]  in_pins,
    output logic [7:0]  out_pins,
    output logic        timer_irq
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    // ------------------------------------------------------------------
    // Address decode (byte offset within the word is ignored)
    // ------------------------------------------------------------------
    logic [29:0] word;
    logic        hit_out, hit_in, hit_edge, hit_tmr, hit_sts;
    logic        wr;

    assign word     = addr[31:2];
    assign hit_out  = (word == 30'h200);
    assign hit_in   = (word == 30'h201);
    assign hit_edge = (word == 30'h202);
    assign hit_tmr  = (word == 30'h203);
    assign hit_sts  = (word == 30'h204);
    assign sel      = hit_out | hit_in | hit_edge | hit_tmr | hit_sts;
    assign wr       = we & sel;
    assign mem_we   = we & ~sel;

    // Reads carry no side effects; re and the unused data bits are
    // collected here only so they are visibly consumed.
    logic unused_ok;
    assign unused_ok = &{1'b0, re, addr[1:0], wdata};

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [7:0]       out_q, out_d;
    logic [7:0]       sync1_q, sync2_q;
    logic [7:0]       db_q, db_d;
    logic [7:0]       edge_q, edge_d;
    logic [TMR_W-1:0] reload_q, reload_d;
    logic [TMR_W-1:0] count_q, count_d;
    logic             expired_q, expired_d;

    // ------------------------------------------------------------------
    // Per-bit debounce: the counter tracks how long the synchronized value
    // has disagreed with db; any agreement restarts it, so short glitches
    // never propagate.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_db
            logic [CW-1:0] cnt_q, cnt_d;
            logic          bit_d;

            always_comb begin
                cnt_d = '0;
                bit_d = db_q[gi];
                if (sync2_q[gi] != db_q[gi]) begin
                    if (cnt_q == CW'(DB_CYCLES - 1)) begin
                        bit_d = sync2_q[gi];
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign db_d[gi] = bit_d;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic for the register bank and timer
    // ------------------------------------------------------------------
    logic [7:0] edge_clr;
    logic       sts_clr;
    logic       exp_set;

    always_comb begin
        out_d    = out_q;
        reload_d = reload_q;
        count_d  = count_q;
        exp_set  = 1'b0;
        edge_clr = (wr && hit_edge) ? wdata[7:0] : 8'h00;
        sts_clr  = wr && hit_sts && wdata[0];

        if (wr && hit_out) begin
            out_d = wdata[7:0];
        end

        // A TIMER write overrides the running count and never expires in
        // the same cycle; reload == 0 parks the timer.
        if (wr && hit_tmr) begin
            reload_d = wdata[TMR_W-1:0];
            count_d  = wdata[TMR_W-1:0];
        end else if (reload_q != '0) begin
            if (count_q <= TMR_W'(1)) begin
                count_d = reload_q;
                exp_set = 1'b1;
            end else begin
                count_d = count_q - TMR_W'(1);
            end
        end

        // Sticky bits: a new event in the same cycle as a clear wins.
        edge_d    = (edge_q & ~edge_clr) | (db_d & ~db_q);
        expired_d = (expired_q & ~sts_clr) | exp_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q     <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            edge_q    <= '0;
            reload_q  <= '0;
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            sync1_q   <= in_pins;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            edge_q    <= edge_d;
            reload_q  <= reload_d;
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs and combinational read mux
    // ------------------------------------------------------------------
    assign out_pins  = out_q;
    assign timer_irq = expired_q;

    always_comb begin
        rdata = mem_rdata;
        if (sel) begin
            rdata = '0;
            if (hit_out)  rdata[7:0]       = out_q;
            if (hit_in)   rdata[7:0]       = db_q;
            if (hit_edge) rdata[7:0]       = edge_q;
            if (hit_tmr)  rdata[TMR_W-1:0] = count_q;
            if (hit_sts)  rdata[0]         = expired_q;
        end
    end

endmodule

// File: tb/tb_io_ctrl.sv
// ---------------------------------------------------------------------------
// tb_io_ctrl -- self-checking bench for io_ctrl (DB_CYCLES=4, TMR_W=16).
// Expected values are pushed to a scoreboard queue as stimulus is applied
// and popped when the corresponding DUT output is sampled.
// ---------------------------------------------------------------------------
module tb_io_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic [31:0] rdata;
    logic        sel;
    logic [7:0]  in_pins;
    logic [7:0]  out_pins;
    logic        timer_irq;

    io_ctrl #(.DB_CYCLES(4), .TMR_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .wdata     (wdata),
        .we        (we),
        .re        (re),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .rdata     (rdata),
        .sel       (sel),
        .in_pins   (in_pins),
        .out_pins  (out_pins),
        .timer_irq (timer_irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Simple data memory model behind the controller
    logic [31:0] dmem [0:1023];
    always @(posedge clk) begin
        if (mem_we) dmem[addr[11:2]] <= wdata;
    end
    assign mem_rdata = dmem[addr[11:2]];

    // Scoreboard
    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_eq(e.tag, obs, e.exp);
        end
    endtask

    task automatic expect_sig(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        sb_push(tag, exp);
        sb_pop_check(obs);
    endtask

    // Combinational bus read, sampled 1 time unit after driving the address
    task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        sb_push(tag, exp);
        addr = a;
        re   = 1'b1;
        #1;
        sb_pop_check(rdata);
        re   = 1'b0;
    endtask

    // Bus write: checks mem_we before the edge, commits on the next rising
    // edge and returns at the following falling edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic exp_mwe);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        sb_push($sformatf("mem_we@%0h", a), {31'd0, exp_mwe});
        #1;
        sb_pop_check({31'd0, mem_we});
        @(negedge clk);
        we = 1'b0;
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        addr    = 32'h0;
        wdata   = 32'h0;
        we      = 1'b0;
        re      = 1'b0;
        in_pins = 8'h00;
        for (int i = 0; i < 1024; i++) dmem[i] = 32'h0;
        dmem[10'h200] = 32'h12345678;
        dmem[10'h010] = 32'hDEADBEEF;

        // Reset state
        repeat (3) @(negedge clk);
        expect_sig("rst_out_pins", {24'd0, out_pins}, 32'h0);
        expect_sig("rst_irq", {31'd0, timer_irq}, 32'h0);
        bus_read("rst_in", 32'h804, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // OUT register and address decode
        bus_write(32'h800, 32'h000000A5, 1'b0);
        expect_sig("out_pins", {24'd0, out_pins}, 32'hA5);
        bus_read("rd_out", 32'h800, 32'hA5);
        bus_read("rd_out_byteoff", 32'h802, 32'hA5);
        expect_sig("sel_io", {31'd0, sel}, 32'd1);
        expect_sig("dmem_800_kept", dmem[10'h200], 32'h12345678);
        bus_write(32'h804, 32'hFF, 1'b0);
        bus_read("in_ro", 32'h804, 32'h0);

        // Memory fall-through
        bus_read("mem_rd", 32'h40, 32'hDEADBEEF);
        expect_sig("sel_mem", {31'd0, sel}, 32'd0);
        bus_write(32'h40, 32'h11223344, 1'b1);
        bus_read("mem_rd_back", 32'h40, 32'h11223344);

        // Debounce latency: change sampled at edge k, visible after k+5
        in_pins = 8'h81;
        repeat (5) @(negedge clk);
        bus_read("in_k4", 32'h804, 32'h0);
        @(negedge clk);
        bus_read("in_k5", 32'h804, 32'h81);
        bus_read("edge_k5", 32'h808, 32'h81);

        // 3-cycle glitch on bit 1 is filtered
        in_pins = 8'h83;
        repeat (3) @(negedge clk);
        in_pins = 8'h81;
        repeat (10) @(negedge clk);
        bus_read("in_glitch", 32'h804, 32'h81);
        bus_read("edge_glitch", 32'h808, 32'h81);

        // EDGE write-1-to-clear
        bus_write(32'h808, 32'h01, 1'b0);
        bus_read("edge_clr0", 32'h808, 32'h80);

        // Bit 7 falls, clear it, then rise coincides with a clear: set wins
        in_pins = 8'h01;
        repeat (8) @(negedge clk);
        bus_read("in_fall7", 32'h804, 32'h01);
        bus_write(32'h808, 32'h80, 1'b0);
        bus_read("edge_clr7", 32'h808, 32'h00);
        in_pins = 8'h81;
        repeat (5) @(negedge clk);
        bus_write(32'h808, 32'h80, 1'b0);
        bus_read("edge_setwins", 32'h808, 32'h80);
        bus_read("in_rise7", 32'h804, 32'h81);

        // Timer with reload 3
        bus_write(32'h80C, 32'd3, 1'b0);
        bus_read("tmr_c0", 32'h80C, 32'd3);
        expect_sig("irq_c0", {31'd0, timer_irq}, 32'd0);
        @(negedge clk);
        bus_read("tmr_c1", 32'h80C, 32'd2);
        expect_sig("irq_c1", {31'd0, timer_irq}, 32'd0);
        @(negedge clk);
        bus_read("tmr_c2", 32'h80C, 32'd1);
        expect_sig("irq_c2", {31'd0, timer_irq}, 32'd0);
        @(negedge clk);
        bus_read("tmr_c3", 32'h80C, 32'd3);
        expect_sig("irq_c3", {31'd0, timer_irq}, 32'd1);
        bus_read("sts_c3", 32'h810, 32'd1);
        @(negedge clk);
        bus_read("tmr_c4", 32'h80C, 32'd2);
        bus_write(32'h810, 32'd1, 1'b0);
        expect_sig("irq_cleared", {31'd0, timer_irq}, 32'd0);
        bus_read("tmr_c5", 32'h80C, 32'd1);
        @(negedge clk);
        expect_sig("irq_period2", {31'd0, timer_irq}, 32'd1);
        bus_read("tmr_c6", 32'h80C, 32'd3);

        // Disable timer
        bus_write(32'h80C, 32'd0, 1'b0);
        bus_write(32'h810, 32'd1, 1'b0);
        repeat (6) @(negedge clk);
        expect_sig("irq_disabled", {31'd0, timer_irq}, 32'd0);
        bus_read("tmr_frozen", 32'h80C, 32'd0);
        bus_read("sts_disabled", 32'h810, 32'd0);

        // Reload 1: expires every cycle; expiry beats a same-cycle clear
        bus_write(32'h80C, 32'd1, 1'b0);
        expect_sig("irq_r1_w", {31'd0, timer_irq}, 32'd0);
        @(negedge clk);
        expect_sig("irq_r1", {31'd0, timer_irq}, 32'd1);
        bus_read("tmr_r1", 32'h80C, 32'd1);
        bus_write(32'h810, 32'd1, 1'b0);
        expect_sig("irq_setwins", {31'd0, timer_irq}, 32'd1);

        // Full-width reload
        bus_write(32'h80C, 32'h0000FFFF, 1'b0);
        bus_read("tmr_max", 32'h80C, 32'h0000FFFF);
        @(negedge clk);
        bus_read("tmr_max_dec", 32'h80C, 32'h0000FFFE);

        // Asynchronous reset mid-period and mid-debounce
        bus_write(32'h80C, 32'd5, 1'b0);
        in_pins = 8'h00;
        repeat (2) @(negedge clk);
        expect_sig("pre_rst_out", {24'd0, out_pins}, 32'hA5);
        #2;
        reset = 1'b1;
        #1;
        expect_sig("async_rst_out", {24'd0, out_pins}, 32'h0);
        expect_sig("async_rst_irq", {31'd0, timer_irq}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        bus_read("post_rst_tmr", 32'h80C, 32'h0);
        @(negedge clk);
        bus_read("post_rst_tmr_hold", 32'h80C, 32'h0);
        bus_read("post_rst_in", 32'h804, 32'h0);
        bus_read("post_rst_edge", 32'h808, 32'h0);

        check_eq("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
